sd_cmd_engine: RTL and testbench

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

---
 rtl/sd_cmd_engine_pkg.sv | 29 ++
 rtl/sd_cmd_engine_crc7.sv | 25 ++
 rtl/sd_cmd_engine.sv | 179 +++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_engine_pkg.sv
// Shared definitions for the SD command engine: FSM encoding, frame geometry
// and the CRC7 generator polynomial.
package sd_cmd_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TX         = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_RX         = 3'd3,
        ST_GAP        = 3'd4
    } state_t;

    localparam int TX_FRAME_LEN     = 48;
    localparam int RSP_SHORT_LEN    = 48;
    localparam int RSP_LONG_LEN     = 136;
    localparam int CRC_PAYLOAD_BITS = 40;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Receive bit positions, counted from the bit after the start bit
    localparam int SHORT_CRC_END   = 39;
    localparam int SHORT_RSP_FIRST = 1;
    localparam int LONG_DATA_FIRST = 7;
    localparam int LONG_CRC_END    = 127;
    localparam int RX_SHORT_LAST   = RSP_SHORT_LEN - 2;
    localparam int RX_LONG_LAST    = RSP_LONG_LEN - 2;

endpackage

// File: rtl/sd_cmd_engine_crc7.sv
// Bit-serial CRC7 accumulator; clear has priority over enable.
module sd_crc7
    import sd_cmd_engine_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc_reg <= '0;
        end else if (enable) begin
            crc_reg <= {crc_reg[5:0], 1'b0} ^ ({7{bit_in ^ crc_reg[6]}} & CRC7_POLY);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD command-line engine: serialises a 48-bit command, waits for and
// captures the short or long response, then enforces the inter-command gap.
module sd_cmd_engine
    import sd_cmd_engine_pkg::*;
#(
    parameter int NCR_MAX = 64,
    parameter int NCC     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_locked,
    input  logic         i_cmd_stb,
    input  logic [5:0]   i_cmd_index,
    input  logic [31:0]  i_cmd_arg,
    input  logic         i_rsp_en,
    input  logic         i_rsp_long,
    output logic         o_busy,
    output logic         o_done_stb,
    output logic [127:0] o_rsp,
    output logic         o_crc_err,
    output logic         o_end_err,
    output logic         o_timeout,
    output logic         o_sd_cmd_dir,
    output logic         o_sd_cmd_out,
    input  logic         i_sd_cmd_in
);

    localparam int CW = 16;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic [39:0]    tx_shift_reg;
    logic           rsp_en_reg, rsp_long_reg;
    logic [127:0]   rsp_reg;
    logic [6:0]     crc_field_reg;
    logic           crc_err_reg, end_err_reg, timeout_reg;
    logic [6:0]     crc_tx, crc_rx;

    logic           accept, start_seen, wait_expired;
    logic           tx_payload, tx_last, rx_last, gap_last, tx_bit;
    logic           rx_crc_win, rx_field_win, rx_rsp_win, rx_shift_bit;
    logic [2:0]     crc_idx;

    assign accept       = (state_reg == ST_IDLE) && i_cmd_stb && i_locked;
    assign tx_payload   = cnt_reg < CW'(CRC_PAYLOAD_BITS);
    assign tx_last      = cnt_reg == CW'(TX_FRAME_LEN - 1);
    assign crc_idx      = 3'(CW'(TX_FRAME_LEN - 2) - cnt_reg);
    assign start_seen   = (state_reg == ST_WAIT_START) && !i_sd_cmd_in;
    assign wait_expired = (state_reg == ST_WAIT_START) && i_sd_cmd_in
                          && (cnt_reg == CW'(NCR_MAX - 1));
    assign rx_last      = cnt_reg == (rsp_long_reg ? CW'(RX_LONG_LAST) : CW'(RX_SHORT_LAST));
    assign gap_last     = cnt_reg == CW'(NCC - 1);

    // The short CRC also covers the start bit, fed while still in WAIT_START
    always_comb begin
        if (rsp_long_reg) begin
            rx_crc_win   = (cnt_reg >= CW'(LONG_DATA_FIRST)) && (cnt_reg < CW'(LONG_CRC_END));
            rx_field_win = (cnt_reg >= CW'(LONG_CRC_END)) && (cnt_reg < CW'(RX_LONG_LAST));
            rx_rsp_win   = cnt_reg >= CW'(LONG_DATA_FIRST);
        end else begin
            rx_crc_win   = cnt_reg < CW'(SHORT_CRC_END);
            rx_field_win = (cnt_reg >= CW'(SHORT_CRC_END)) && (cnt_reg < CW'(RX_SHORT_LAST));
            rx_rsp_win   = (cnt_reg >= CW'(SHORT_RSP_FIRST)) && (cnt_reg < CW'(SHORT_CRC_END));
        end
    end

    // Long responses shift a 0 in place of the end bit so o_rsp[0] reads 0
    assign rx_shift_bit = (rsp_long_reg && rx_last) ? 1'b0 : i_sd_cmd_in;

    always_comb begin
        if (tx_payload) begin
            tx_bit = tx_shift_reg[39];
        end else if (tx_last) begin
            tx_bit = 1'b1;
        end else begin
            tx_bit = crc_tx[crc_idx];
        end
    end

    sd_crc7 u_crc_tx (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable ((state_reg == ST_TX) && tx_payload),
        .bit_in (tx_shift_reg[39]),
        .crc    (crc_tx)
    );

    sd_crc7 u_crc_rx (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable ((start_seen && !rsp_long_reg) || ((state_reg == ST_RX) && rx_crc_win)),
        .bit_in (i_sd_cmd_in),
        .crc    (crc_rx)
    );

    always_comb begin
        state_next   = state_reg;
        o_busy       = 1'b1;
        o_done_stb   = 1'b0;
        o_sd_cmd_dir = 1'b0;
        o_sd_cmd_out = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (accept) state_next = ST_TX;
            end
            ST_TX: begin
                o_sd_cmd_dir = 1'b1;
                o_sd_cmd_out = tx_bit;
                if (tx_last) state_next = rsp_en_reg ? ST_WAIT_START : ST_GAP;
            end
            ST_WAIT_START: begin
                if (start_seen)        state_next = ST_RX;
                else if (wait_expired) state_next = ST_GAP;
            end
            ST_RX: begin
                if (rx_last) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_last) begin
                    o_done_stb = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            tx_shift_reg  <= '0;
            rsp_en_reg    <= 1'b0;
            rsp_long_reg  <= 1'b0;
            rsp_reg       <= '0;
            crc_field_reg <= '0;
            crc_err_reg   <= 1'b0;
            end_err_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (state_next != state_reg) ? '0 : cnt_reg + CW'(1);

            if (accept) begin
                tx_shift_reg <= {2'b01, i_cmd_index, i_cmd_arg};
                rsp_en_reg   <= i_rsp_en;
                rsp_long_reg <= i_rsp_long;
                crc_err_reg  <= 1'b0;
                end_err_reg  <= 1'b0;
                timeout_reg  <= 1'b0;
            end

            if ((state_reg == ST_TX) && tx_payload) begin
                tx_shift_reg <= {tx_shift_reg[38:0], 1'b0};
            end

            if (start_seen) rsp_reg <= '0;
            if (wait_expired) timeout_reg <= 1'b1;

            if (state_reg == ST_RX) begin
                if (rx_rsp_win)   rsp_reg       <= {rsp_reg[126:0], rx_shift_bit};
                if (rx_field_win) crc_field_reg <= {crc_field_reg[5:0], i_sd_cmd_in};
                if (rx_last) begin
                    crc_err_reg <= (crc_rx != crc_field_reg);
                    end_err_reg <= !i_sd_cmd_in;
                end
            end
        end
    end

    assign o_rsp     = rsp_reg;
    assign o_crc_err = crc_err_reg;
    assign o_end_err = end_err_reg;
    assign o_timeout = timeout_reg;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: directed SD scenarios plus random
// transactions against a frame-level reference model.
module tb_sd_cmd_engine;

    localparam int NCR_MAX = 64;
    localparam int NCC     = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_locked = 1'b1;
    logic         i_cmd_stb = 1'b0;
    logic [5:0]   i_cmd_index = '0;
    logic [31:0]  i_cmd_arg = '0;
    logic         i_rsp_en = 1'b0;
    logic         i_rsp_long = 1'b0;
    logic         o_busy, o_done_stb, o_crc_err, o_end_err, o_timeout;
    logic [127:0] o_rsp;
    logic         o_sd_cmd_dir, o_sd_cmd_out;
    logic         i_sd_cmd_in = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [127:0] model_rsp = '0;

    sd_cmd_engine #(.NCR_MAX(NCR_MAX), .NCC(NCC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_locked     (i_locked),
        .i_cmd_stb    (i_cmd_stb),
        .i_cmd_index  (i_cmd_index),
        .i_cmd_arg    (i_cmd_arg),
        .i_rsp_en     (i_rsp_en),
        .i_rsp_long   (i_rsp_long),
        .o_busy       (o_busy),
        .o_done_stb   (o_done_stb),
        .o_rsp        (o_rsp),
        .o_crc_err    (o_crc_err),
        .o_end_err    (o_end_err),
        .o_timeout    (o_timeout),
        .o_sd_cmd_dir (o_sd_cmd_dir),
        .o_sd_cmd_out (o_sd_cmd_out),
        .i_sd_cmd_in  (i_sd_cmd_in)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // CRC7 as the remainder of polynomial long division of data(x)*x^7 by 0x89
    function automatic logic [6:0] crc7_div(input logic [135:0] data, input int n);
        logic [142:0] m;
        m = 143'(data) << 7;
        for (int i = n + 6; i >= 7; i--) begin
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        end
        return m[6:0];
    endfunction

    function automatic logic [47:0] make_short(input logic [5:0] idx, input logic [31:0] body,
                                               input bit flip_crc, input bit end_bit);
        logic [39:0] head;
        logic [6:0]  crc;
        head = {2'b00, idx, body};
        crc  = crc7_div(136'(head), 40) ^ (flip_crc ? 7'h04 : 7'h00);
        return {head, crc, end_bit};
    endfunction

    function automatic logic [135:0] make_long(input logic [119:0] cid, input bit flip_crc,
                                               input bit end_bit);
        logic [6:0] crc;
        crc = crc7_div(136'(cid), 120) ^ (flip_crc ? 7'h10 : 7'h00);
        return {2'b00, 6'h3f, cid, crc, end_bit};
    endfunction

    task automatic run_txn(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input bit rsp_en, input bit rsp_long, input int dly,
                           input logic [135:0] frame, output logic [47:0] tx_seen);
        logic [39:0]  cmd;
        logic [47:0]  exp_tx;
        logic [127:0] exp_rsp;
        bit           exp_crc, exp_end, exp_to, dir_ok, busy_ok, line_ok;
        int           exp_done, done_cyc, cyc, n, c, errs0;
        bit           line_q[$];

        errs0   = errors;
        cmd     = {2'b01, idx, arg};
        exp_tx  = {cmd, crc7_div(136'(cmd), 40), 1'b1};
        exp_rsp = model_rsp;
        exp_crc = 1'b0;
        exp_end = 1'b0;
        exp_to  = 1'b0;
        n       = rsp_long ? 136 : 48;
        if (!rsp_en) begin
            exp_done = 48 + NCC;
        end else if (dly >= NCR_MAX) begin
            exp_to   = 1'b1;
            exp_done = 48 + NCR_MAX + NCC;
        end else begin
            for (int i = 0; i < dly; i++) line_q.push_back(1'b1);
            for (int i = n - 1; i >= 0; i--) line_q.push_back(frame[i]);
            exp_done = 49 + dly + (n - 1) + NCC;
            if (rsp_long) begin
                exp_rsp = {frame[127:1], 1'b0};
                exp_crc = crc7_div(136'(frame[127:8]), 120) != frame[7:1];
            end else begin
                exp_rsp = {90'b0, frame[45:8]};
                exp_crc = crc7_div(136'(frame[47:8]), 40) != frame[7:1];
            end
            exp_end = !frame[0];
        end

        // cycle 0: request; later input changes and lock loss must not matter
        i_locked    = 1'b1;
        i_cmd_stb   = 1'b1;
        i_cmd_index = idx;
        i_cmd_arg   = arg;
        i_rsp_en    = rsp_en;
        i_rsp_long  = rsp_long;
        i_sd_cmd_in = 1'b1;
        step();
        cyc         = 1;
        i_cmd_stb   = 1'b0;
        i_cmd_index = 6'($urandom);
        i_cmd_arg   = $urandom;
        i_rsp_en    = 1'($urandom);
        i_rsp_long  = 1'($urandom);
        i_locked    = 1'($urandom);

        tx_seen = '0;
        dir_ok  = 1'b1;
        busy_ok = 1'b1;
        line_ok = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tx_seen = {tx_seen[46:0], o_sd_cmd_out};
            if (!o_sd_cmd_dir) dir_ok = 1'b0;
            if (!o_busy || o_done_stb) busy_ok = 1'b0;
            step();
            cyc++;
        end

        done_cyc = -1;
        c = 0;
        while (cyc <= exp_done + 5) begin
            if (o_sd_cmd_dir || !o_sd_cmd_out) line_ok = 1'b0;
            if (!o_busy) busy_ok = 1'b0;
            if (o_done_stb) begin
                done_cyc = cyc;
                break;
            end
            i_sd_cmd_in = (c < line_q.size()) ? line_q[c] : 1'b1;
            step();
            cyc++;
            c++;
        end
        i_sd_cmd_in = 1'b1;

        checks++;
        if (tx_seen !== exp_tx) begin
            errors++;
            $display("FAIL %s tx_frame got %012h want %012h", name, tx_seen, exp_tx);
        end
        checks++;
        if (!dir_ok || !line_ok) begin
            errors++;
            $display("FAIL %s cmd_dir got tx_drive=%0b released=%0b want 1 1", name, dir_ok, line_ok);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy got dropped want held", name);
        end
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_done);
        end
        checks++;
        if ({o_crc_err, o_end_err, o_timeout} !== {exp_crc, exp_end, exp_to}) begin
            errors++;
            $display("FAIL %s flags(crc,end,to) got %b want %b", name,
                     {o_crc_err, o_end_err, o_timeout}, {exp_crc, exp_end, exp_to});
        end
        checks++;
        if (o_rsp !== exp_rsp) begin
            errors++;
            $display("FAIL %s rsp got %032h want %032h", name, o_rsp, exp_rsp);
        end
        model_rsp = exp_rsp;

        step();
        checks++;
        if (o_busy !== 1'b0 || o_done_stb !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done busy/done got %b%b want 00", name, o_busy, o_done_stb);
        end
        $display("TXN %-10s idx=%0d arg=%08h rsp=%0d long=%0d dly=%0d done@%0d %s",
                 name, idx, arg, rsp_en, rsp_long, dly, done_cyc,
                 (errors == errs0) ? "ok" : "bad");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({o_sd_cmd_dir, o_sd_cmd_out, o_busy, o_done_stb} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_line got dir/out/busy/done=%b want 0100",
                     {o_sd_cmd_dir, o_sd_cmd_out, o_busy, o_done_stb});
        end
        checks++;
        if (o_rsp !== 128'b0 || {o_crc_err, o_end_err, o_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status got rsp=%032h flags=%b want 0 000", o_rsp,
                     {o_crc_err, o_end_err, o_timeout});
        end
        rst = 1'b0;
        model_rsp = '0;
        step();
        $display("TXN reset done");
    endtask

    task automatic test_cmd0();
        logic [47:0] tx;
        run_txn("cmd0", 6'd0, 32'h0, 1'b0, 1'b0, 0, '0, tx);
        checks++;
        if (tx !== 48'h400000000095) begin
            errors++;
            $display("FAIL cmd0_literal got %012h want 400000000095", tx);
        end
    endtask

    task automatic test_cmd8();
        logic [47:0] tx;
        run_txn("cmd8", 6'd8, 32'h000001AA, 1'b1, 1'b0, int'($urandom_range(0, 10)),
                136'(48'h08000001AA13), tx);
        checks++;
        if (tx !== 48'h48000001AA87 || o_rsp[37:0] !== {6'h08, 32'h000001AA}) begin
            errors++;
            $display("FAIL cmd8_literal got tx=%012h rsp=%010h want 48000001AA87 08000001AA",
                     tx, o_rsp[37:0]);
        end
    endtask

    task automatic test_crc_err();
        logic [47:0] tx;
        run_txn("cmd17_crc", 6'd17, 32'h0, 1'b1, 1'b0, 3,
                136'(make_short(6'd17, 32'h00000900, 1'b1, 1'b1)), tx);
        checks++;
        if (o_crc_err !== 1'b1 || o_rsp[37:0] !== {6'd17, 32'h00000900}) begin
            errors++;
            $display("FAIL crc_flip got crc_err=%b rsp=%010h want 1 %010h", o_crc_err,
                     o_rsp[37:0], {6'd17, 32'h00000900});
        end
    endtask

    task automatic test_timeout();
        logic [47:0] tx;
        run_txn("timeout", 6'd55, 32'h0, 1'b1, 1'b0, NCR_MAX, '0, tx);
        checks++;
        if (o_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag got %b want 1", o_timeout);
        end
        run_txn("late_start", 6'd13, 32'h12340000, 1'b1, 1'b0, NCR_MAX - 1,
                136'(make_short(6'd13, 32'h00000E00, 1'b0, 1'b1)), tx);
        checks++;
        if (o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL late_start_timeout got %b want 0", o_timeout);
        end
    endtask

    task automatic test_r2();
        logic [47:0]  tx;
        logic [119:0] cid;
        logic [127:0] cid_full;
        cid      = 120'h035344535530384780105A3C4B2D11;
        cid_full = {cid, crc7_div(136'(cid), 120), 1'b1};
        run_txn("cmd2_r2", 6'd2, 32'h0, 1'b1, 1'b1, 2, make_long(cid, 1'b0, 1'b1), tx);
        checks++;
        if (o_rsp[127:1] !== cid_full[127:1] || o_rsp[0] !== 1'b0) begin
            errors++;
            $display("FAIL r2_cid got %032h want %032h", o_rsp, {cid_full[127:1], 1'b0});
        end
        run_txn("cmd2_end0", 6'd2, 32'h0, 1'b1, 1'b1, 5, make_long(cid, 1'b0, 1'b0), tx);
        checks++;
        if (o_end_err !== 1'b1 || o_crc_err !== 1'b0) begin
            errors++;
            $display("FAIL r2_end_err got end=%b crc=%b want 1 0", o_end_err, o_crc_err);
        end
    endtask

    task automatic test_lock_and_reset();
        bit busy_seen, done_seen;
        i_locked  = 1'b0;
        i_cmd_stb = 1'b1;
        busy_seen = 1'b0;
        repeat (10) begin
            step();
            if (o_busy || o_sd_cmd_dir) busy_seen = 1'b1;
        end
        i_cmd_stb = 1'b0;
        step();
        i_locked = 1'b1;
        checks++;
        if (busy_seen) begin
            errors++;
            $display("FAIL unlocked_ignore got busy=1 want 0");
        end
        $display("TXN unlocked request ignored check");

        i_cmd_stb   = 1'b1;
        i_cmd_index = 6'd24;
        i_cmd_arg   = 32'hDEADBEEF;
        i_rsp_en    = 1'b1;
        i_rsp_long  = 1'b0;
        step();
        i_cmd_stb = 1'b0;
        repeat (19) step();
        checks++;
        if (o_sd_cmd_dir !== 1'b1) begin
            errors++;
            $display("FAIL bit20_driving got dir=%b want 1", o_sd_cmd_dir);
        end
        rst = 1'b1;
        step();
        checks++;
        if (o_sd_cmd_dir !== 1'b0 || o_sd_cmd_out !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got dir=%b out=%b busy=%b want 0 1 0",
                     o_sd_cmd_dir, o_sd_cmd_out, o_busy);
        end
        rst = 1'b0;
        model_rsp = '0;
        done_seen = 1'b0;
        repeat (150) begin
            step();
            if (o_done_stb || o_busy) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL reset_no_done got done/busy activity want none");
        end
        $display("TXN reset at tx bit 20 check");
    endtask

    task automatic test_random();
        logic [47:0]  tx;
        logic [135:0] frame;
        logic [127:0] wide;
        logic [5:0]   idx;
        logic [31:0]  arg;
        bit           rsp_en, rsp_long;
        int           dly;
        for (int t = 0; t < 24; t++) begin
            idx      = 6'($urandom);
            arg      = $urandom;
            rsp_en   = ($urandom_range(0, 3) != 0);
            rsp_long = rsp_en && ($urandom_range(0, 2) == 0);
            dly      = ($urandom_range(0, 7) == 0) ? NCR_MAX : int'($urandom_range(0, NCR_MAX - 1));
            wide     = {$urandom, $urandom, $urandom, $urandom};
            if (rsp_long)
                frame = make_long(wide[119:0], $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            else
                frame = 136'(make_short(idx, wide[31:0], $urandom_range(0, 3) == 0,
                                        $urandom_range(0, 3) != 0));
            run_txn($sformatf("rand%0d", t), idx, arg, rsp_en, rsp_long, dly, frame, tx);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_crc_err();
        test_timeout();
        test_r2();
        test_lock_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
